// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns parsed note events to a bank of voices,
// stealing the oldest voice when full, with sustain-pedal hold and all-notes-off.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 8,
    parameter int unsigned CNT_W      = $clog2(NUM_VOICES + 1)
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_event_valid,
    output logic                      o_event_ready,
    input  logic                      i_event_on,
    input  logic [6:0]                i_event_note,
    input  logic [6:0]                i_event_vel,
    input  logic                      i_sustain,
    input  logic                      i_all_off,
    output logic [NUM_VOICES*7-1:0]   o_voice_note,
    output logic [NUM_VOICES*7-1:0]   o_voice_vel,
    output logic [NUM_VOICES-1:0]     o_voice_gate,
    output logic [NUM_VOICES-1:0]     o_voice_trig,
    output logic                      o_steal,
    output logic [CNT_W-1:0]          o_active_count
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Voice state
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            r_vel  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic [NUM_VOICES-1:0] r_held;

    logic [6:0]            w_note [NUM_VOICES];
    logic [6:0]            w_vel  [NUM_VOICES];
    logic [AGE_W-1:0]      w_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_gate;
    logic [NUM_VOICES-1:0] w_held;

    // Control and scan bookkeeping
    logic [1:0]       r_state,     w_state;
    logic [IDX_W-1:0] r_scan_idx,  w_scan_idx;
    logic             r_ev_on,     w_ev_on;
    logic [6:0]       r_ev_note,   w_ev_note;
    logic [6:0]       r_ev_vel,    w_ev_vel;
    logic             r_match_vld, w_match_vld;
    logic [IDX_W-1:0] r_match_idx, w_match_idx;
    logic             r_free_vld,  w_free_vld;
    logic [IDX_W-1:0] r_free_idx,  w_free_idx;
    logic             r_off_vld,   w_off_vld;
    logic [IDX_W-1:0] r_off_idx,   w_off_idx;
    logic [IDX_W-1:0] r_old_idx,   w_old_idx;
    logic [AGE_W-1:0] r_old_age,   w_old_age;
    logic             r_sus_q;
    logic             r_sus_pend,  w_sus_pend;
    logic             r_aoff_pend, w_aoff_pend;
    logic             r_ready,     w_ready;
    logic [NUM_VOICES-1:0] r_trig, w_trig;
    logic             r_steal,     w_steal;
    logic [CNT_W-1:0] r_count,     w_count;

    logic             w_hs;
    logic             w_sus_fall;
    logic [IDX_W-1:0] w_sel;
    logic             w_cur_busy;
    logic             w_cur_hit;

    assign w_hs       = i_event_valid & r_ready;
    assign w_sus_fall = r_sus_q & ~i_sustain;
    assign w_sel      = r_match_vld ? r_match_idx : (r_free_vld ? r_free_idx : r_old_idx);
    assign w_cur_busy = r_gate[r_scan_idx] | r_held[r_scan_idx];
    assign w_cur_hit  = (r_note[r_scan_idx] == r_ev_note);

    // Next-state and voice-update logic
    always_comb begin
        w_state     = r_state;
        w_scan_idx  = r_scan_idx;
        w_ev_on     = r_ev_on;
        w_ev_note   = r_ev_note;
        w_ev_vel    = r_ev_vel;
        w_match_vld = r_match_vld;
        w_match_idx = r_match_idx;
        w_free_vld  = r_free_vld;
        w_free_idx  = r_free_idx;
        w_off_vld   = r_off_vld;
        w_off_idx   = r_off_idx;
        w_old_idx   = r_old_idx;
        w_old_age   = r_old_age;
        w_sus_pend  = r_sus_pend;
        w_aoff_pend = r_aoff_pend;
        w_note      = r_note;
        w_vel       = r_vel;
        w_age       = r_age;
        w_gate      = r_gate;
        w_held      = r_held;
        w_trig      = '0;
        w_steal     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_aoff_pend || r_sus_pend) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (r_aoff_pend) begin
                            w_gate[v] = 1'b0;
                            w_held[v] = 1'b0;
                            w_age[v]  = '0;
                        end else if (r_held[v]) begin
                            w_gate[v] = 1'b0;
                            w_held[v] = 1'b0;
                        end
                    end
                    w_aoff_pend = 1'b0;
                    w_sus_pend  = 1'b0;
                end else if (w_hs) begin
                    // Zero velocity note-on is folded into note-off here
                    w_ev_on     = i_event_on & (i_event_vel != 7'd0);
                    w_ev_note   = i_event_note;
                    w_ev_vel    = i_event_vel;
                    w_match_vld = 1'b0;
                    w_free_vld  = 1'b0;
                    w_off_vld   = 1'b0;
                    w_old_idx   = '0;
                    w_old_age   = '0;
                    w_scan_idx  = '0;
                    w_state     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!r_match_vld && w_cur_hit && w_cur_busy) begin
                    w_match_vld = 1'b1;
                    w_match_idx = r_scan_idx;
                end
                if (!r_free_vld && !w_cur_busy) begin
                    w_free_vld = 1'b1;
                    w_free_idx = r_scan_idx;
                end
                if (!r_off_vld && w_cur_hit && r_gate[r_scan_idx] && !r_held[r_scan_idx]) begin
                    w_off_vld = 1'b1;
                    w_off_idx = r_scan_idx;
                end
                if (r_age[r_scan_idx] > r_old_age) begin
                    w_old_age = r_age[r_scan_idx];
                    w_old_idx = r_scan_idx;
                end
                if (r_scan_idx == LAST_IDX) begin
                    w_state = S_COMMIT;
                end else begin
                    w_scan_idx = r_scan_idx + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                if (r_ev_on) begin
                    w_steal = ~r_match_vld & ~r_free_vld;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == w_sel) begin
                            w_note[v] = r_ev_note;
                            w_vel[v]  = r_ev_vel;
                            w_gate[v] = 1'b1;
                            w_held[v] = 1'b0;
                            w_age[v]  = '0;
                            w_trig[v] = 1'b1;
                        end else if (r_gate[v] && (r_age[v] != AGE_MAX)) begin
                            w_age[v] = r_age[v] + AGE_W'(1);
                        end
                    end
                end else if (r_off_vld) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == r_off_idx) begin
                            if (i_sustain) begin
                                w_held[v] = 1'b1;
                            end else begin
                                w_gate[v] = 1'b0;
                            end
                        end
                    end
                end
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        // New requests win over a service in the same cycle
        if (i_all_off) begin
            w_aoff_pend = 1'b1;
        end
        if (w_sus_fall) begin
            w_sus_pend = 1'b1;
        end

        w_ready = (w_state == S_IDLE) && !w_sus_pend && !w_aoff_pend;

        w_count = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_count = w_count + CNT_W'(w_gate[v]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_scan_idx  <= '0;
            r_ev_on     <= 1'b0;
            r_ev_note   <= '0;
            r_ev_vel    <= '0;
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
            r_off_vld   <= 1'b0;
            r_off_idx   <= '0;
            r_old_idx   <= '0;
            r_old_age   <= '0;
            r_sus_q     <= 1'b0;
            r_sus_pend  <= 1'b0;
            r_aoff_pend <= 1'b0;
            r_ready     <= 1'b0;
            r_trig      <= '0;
            r_steal     <= 1'b0;
            r_count     <= '0;
            r_gate      <= '0;
            r_held      <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_vel[v]  <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_state     <= w_state;
            r_scan_idx  <= w_scan_idx;
            r_ev_on     <= w_ev_on;
            r_ev_note   <= w_ev_note;
            r_ev_vel    <= w_ev_vel;
            r_match_vld <= w_match_vld;
            r_match_idx <= w_match_idx;
            r_free_vld  <= w_free_vld;
            r_free_idx  <= w_free_idx;
            r_off_vld   <= w_off_vld;
            r_off_idx   <= w_off_idx;
            r_old_idx   <= w_old_idx;
            r_old_age   <= w_old_age;
            r_sus_q     <= i_sustain;
            r_sus_pend  <= w_sus_pend;
            r_aoff_pend <= w_aoff_pend;
            r_ready     <= w_ready;
            r_trig      <= w_trig;
            r_steal     <= w_steal;
            r_count     <= w_count;
            r_gate      <= w_gate;
            r_held      <= w_held;
            r_note      <= w_note;
            r_vel       <= w_vel;
            r_age       <= w_age;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign o_voice_note[7*g +: 7] = r_note[g];
        assign o_voice_vel[7*g +: 7]  = r_vel[g];
    end

    assign o_event_ready  = r_ready;
    assign o_voice_gate   = r_gate;
    assign o_voice_trig   = r_trig;
    assign o_steal        = r_steal;
    assign o_active_count = r_count;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices): allocation, steal, retrigger,
// sustain, all-off and reset abort, against hand-computed values.
module tb_voice_allocator;

    localparam int unsigned NV    = 4;
    localparam int unsigned CNT_W = $clog2(NV + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ev_valid;
    logic              rdy;
    logic              ev_on;
    logic [6:0]        ev_note;
    logic [6:0]        ev_vel;
    logic              sustain;
    logic              all_off;
    logic [NV*7-1:0]   v_note;
    logic [NV*7-1:0]   v_vel;
    logic [NV-1:0]     v_gate;
    logic [NV-1:0]     v_trig;
    logic              steal;
    logic [CNT_W-1:0]  act_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [NV-1:0] tg;
    logic          st;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .CNT_W(CNT_W)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_event_valid  (ev_valid),
        .o_event_ready  (rdy),
        .i_event_on     (ev_on),
        .i_event_note   (ev_note),
        .i_event_vel    (ev_vel),
        .i_sustain      (sustain),
        .i_all_off      (all_off),
        .o_voice_note   (v_note),
        .o_voice_vel    (v_vel),
        .o_voice_gate   (v_gate),
        .o_voice_trig   (v_trig),
        .o_steal        (steal),
        .o_active_count (act_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an event and return one cycle after its handshake edge
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int waited;
        waited   = 0;
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        ev_vel   = vel;
        while (!rdy && waited < 40) begin
            tick();
            waited++;
        end
        if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
        tick();
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
    endtask

    task automatic run_event(input string tag, input logic on, input logic [6:0] note,
                             input logic [6:0] vel, output logic [NV-1:0] trig, output logic stl);
        send(on, note, vel);
        repeat (NV) tick();
        check({tag, "_commit_rdy"}, 32'(rdy), 32'd0);
        check({tag, "_commit_trig"}, 32'(v_trig), 32'd0);
        tick();
        trig = v_trig;
        stl  = steal;
        check({tag, "_rdy"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
        sustain  = 1'b0;
        all_off  = 1'b0;
        repeat (3) tick();
        check("rst_rdy",   32'(rdy),     32'd0);
        check("rst_gate",  32'(v_gate),  32'd0);
        check("rst_count", 32'(act_cnt), 32'd0);
        check("rst_trig",  32'(v_trig),  32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy",  32'(rdy),    32'd1);
        check("post_rst_note", 32'(v_note), 32'd0);

        // First note lands on voice 0
        run_event("on60", 1'b1, 7'd60, 7'd100, tg, st);
        check("on60_trig",  32'(tg),          32'h1);
        check("on60_steal", 32'(st),          32'd0);
        check("on60_gate",  32'(v_gate),      32'h1);
        check("on60_count", 32'(act_cnt),     32'd1);
        check("on60_note",  32'(v_note[6:0]), 32'd60);
        check("on60_vel",   32'(v_vel[6:0]),  32'd100);
        tick();
        check("on60_trig_pulse", 32'(v_trig), 32'd0);

        run_event("on62", 1'b1, 7'd62, 7'd90, tg, st);
        check("on62_trig", 32'(tg), 32'h2);
        run_event("on64", 1'b1, 7'd64, 7'd80, tg, st);
        run_event("on65", 1'b1, 7'd65, 7'd70, tg, st);
        check("full_gate",  32'(v_gate),  32'hF);
        check("full_count", 32'(act_cnt), 32'd4);

        // All busy: voice 0 is oldest and gets stolen
        run_event("on67", 1'b1, 7'd67, 7'd60, tg, st);
        check("steal_trig",  32'(tg),      32'h1);
        check("steal_pulse", 32'(st),      32'd1);
        check("steal_count", 32'(act_cnt), 32'd4);
        check("steal_note",  32'(v_note), 32'({7'd65, 7'd64, 7'd62, 7'd67}));
        check("steal_vel",   32'(v_vel),  32'({7'd70, 7'd80, 7'd90, 7'd60}));
        tick();
        check("steal_one_cycle", 32'(steal), 32'd0);

        // Same note again retriggers voice 1
        run_event("retrig62", 1'b1, 7'd62, 7'd50, tg, st);
        check("retrig_trig",  32'(tg),      32'h2);
        check("retrig_steal", 32'(st),      32'd0);
        check("retrig_count", 32'(act_cnt), 32'd4);
        check("retrig_vel",   32'(v_vel),  32'({7'd70, 7'd80, 7'd50, 7'd60}));

        // Sustain holds a released note until the pedal falls
        sustain = 1'b1;
        tick();
        run_event("off67_sus", 1'b0, 7'd67, 7'd64, tg, st);
        check("sus_trig",  32'(tg),      32'd0);
        check("sus_gate",  32'(v_gate),  32'hF);
        check("sus_count", 32'(act_cnt), 32'd4);
        sustain = 1'b0;
        tick();
        check("sus_fall_gate", 32'(v_gate), 32'hF);
        check("sus_fall_rdy",  32'(rdy),    32'd0);
        tick();
        check("sus_rel_gate",  32'(v_gate),  32'hE);
        check("sus_rel_count", 32'(act_cnt), 32'd3);
        check("sus_rel_rdy",   32'(rdy),     32'd1);

        // Velocity zero note-on releases voice 2
        run_event("vel0_64", 1'b1, 7'd64, 7'd0, tg, st);
        check("vel0_trig",  32'(tg),      32'd0);
        check("vel0_gate",  32'(v_gate),  32'hA);
        check("vel0_count", 32'(act_cnt), 32'd2);

        // Note-off for a silent note changes nothing
        run_event("off70", 1'b0, 7'd70, 7'd0, tg, st);
        check("off70_trig",  32'(tg),      32'd0);
        check("off70_gate",  32'(v_gate),  32'hA);
        check("off70_count", 32'(act_cnt), 32'd2);
        check("off70_note",  32'(v_note), 32'({7'd65, 7'd64, 7'd62, 7'd67}));
        check("off70_vel",   32'(v_vel),  32'({7'd70, 7'd80, 7'd50, 7'd60}));

        // Lowest free voice is reused
        run_event("on72", 1'b1, 7'd72, 7'd33, tg, st);
        check("on72_trig",  32'(tg),          32'h1);
        check("on72_gate",  32'(v_gate),      32'hB);
        check("on72_count", 32'(act_cnt),     32'd3);
        check("on72_note",  32'(v_note[6:0]), 32'd72);

        // All-off during scan: event commits, then everything goes quiet
        send(1'b1, 7'd74, 7'd20);
        all_off = 1'b1;
        tick();
        all_off = 1'b0;
        repeat (3) tick();
        check("aoff_commit_rdy", 32'(rdy), 32'd0);
        tick();
        check("aoff_ev_trig",  32'(v_trig),        32'h4);
        check("aoff_ev_gate",  32'(v_gate),        32'hF);
        check("aoff_ev_count", 32'(act_cnt),       32'd4);
        check("aoff_ev_rdy",   32'(rdy),           32'd0);
        tick();
        check("aoff_gate",  32'(v_gate),          32'd0);
        check("aoff_count", 32'(act_cnt),         32'd0);
        check("aoff_rdy",   32'(rdy),             32'd1);
        check("aoff_note",  32'(v_note[20:14]),   32'd74);

        // Reset in the middle of a scan aborts the event
        send(1'b1, 7'd76, 7'd5);
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_gate",  32'(v_gate),  32'd0);
        check("mrst_note",  32'(v_note),  32'd0);
        check("mrst_vel",   32'(v_vel),   32'd0);
        check("mrst_count", 32'(act_cnt), 32'd0);
        check("mrst_rdy",   32'(rdy),     32'd0);
        rst_n = 1'b1;
        tick();
        check("mrst_rel_rdy", 32'(rdy), 32'd1);
        repeat (8) tick();
        check("mrst_no_leak_gate", 32'(v_gate), 32'd0);
        check("mrst_no_leak_trig", 32'(v_trig), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Parametrised polyphonic voice allocator. It sits between the MIDI parser and a bank of NUM_VOICES sample-generator/envelope channels, replacing the single-voice path. It accepts parsed note-on/note-off events and assigns each note to a voice, stealing the oldest voice when all are busy. It also handles sustain-pedal hold and all-notes-off, and drives per-voice note index, velocity, gate and retrigger strobes.

## Interface
- NUM_VOICES, 4, number of voices, legal range 1..16
- AGE_W, 8, width of per-voice age counter
- CNT_W, $clog2(NUM_VOICES+1), width of OUT_ACTIVE_COUNT
- IN_CLOCK  in  1  system clock (50 MHz)
- IN_RESET_N  in  1  synchronous, active-low reset
- IN_EVENT_VALID  in  1  event present
- OUT_EVENT_READY  out  1  event accepted when VALID&&READY
- IN_EVENT_ON  in  1  1 = note-on, 0 = note-off
- IN_EVENT_NOTE  in  7  MIDI note / frequency-table index
- IN_EVENT_VEL  in  7  velocity 0..127
- IN_SUSTAIN  in  1  sustain pedal level (CC64 >= 64)
- IN_ALL_OFF  in  1  one-cycle all-notes-off pulse
- OUT_VOICE_NOTE  out  NUM_VOICES*7  voice v at [7v+6:7v]
- OUT_VOICE_VEL  out  NUM_VOICES*7  voice v at [7v+6:7v]
- OUT_VOICE_GATE  out  NUM_VOICES  1 = voice sounding/held
- OUT_VOICE_TRIG  out  NUM_VOICES  one-cycle pulse on (re)assignment
- OUT_STEAL  out  1  one-cycle pulse when a voice was stolen
- OUT_ACTIVE_COUNT  out  CNT_W  number of voices with gate=1

## Operation
- Per-voice state: note[7], vel[7], gate, held, age[AGE_W].
- FSM states and transitions:
  - IDLE: on handshake, capture the event fields and go to SCAN.
  - SCAN: examine voice index 0..NUM_VOICES-1, one voice per cycle, then go to COMMIT.
  - COMMIT: apply the decision, then return to IDLE.
- Event fields are sampled only in the handshake cycle.
- SCAN tracks three results:
  - match: lowest index with note==captured note and (gate or held).
  - free: lowest index with gate=0 and held=0.
  - oldest: largest age; ties go to the lowest index.
- A note-on with vel=0 is handled exactly as a note-off.
- Note-on priority:
  - If match exists: retrigger that voice.
  - Otherwise, if free exists: use the free voice.
  - Otherwise: steal the oldest voice and pulse OUT_STEAL.
- Chosen voice on note-on: note/vel loaded, gate=1, held=0, age=0, TRIG[v] pulsed.
- Every other voice with gate=1 increments its age, saturating at 2^AGE_W-1.
- Note-off acts on the lowest index with note match, gate=1 and held=0:
  - IN_SUSTAIN=1 (value at COMMIT): held=1, gate stays 1.
  - Otherwise: gate=0.
  - No match: event dropped with no output change.
- Note and vel persist after the gate drops, for the release tail.
- Sustain release: IN_SUSTAIN is registered every cycle. A falling edge sets a pending flag. In IDLE, the pending flag clears every held voice (gate=0, held=0).
- All-off: an IN_ALL_OFF pulse sets a pending flag. In IDLE it clears gate, held and age on all voices; note and vel are kept.
- If both flags are pending, they are serviced in the same cycle; all-off dominates.
- OUT_ACTIVE_COUNT is the popcount of gates, registered, and updates on the same edge as the gates.

## Timing
- Reset (IN_RESET_N=0 at an edge):
  - All outputs become 0, including READY, and all voice state is cleared.
  - FSM goes to IDLE; pending flags and the sustain register are cleared.
  - Reset mid-SCAN/COMMIT aborts the event with no partial update.
- READY = (state==IDLE) && !sustain_pending && !alloff_pending. READY is 1 in the first cycle after reset is released.
- Pending-flag service takes one IDLE cycle; READY stays low during that cycle.
- Handshake at edge T:
  - SCAN occupies cycles T+1..T+NUM_VOICES.
  - COMMIT is in cycle T+NUM_VOICES+1.
  - Voice outputs, TRIG and STEAL change at the edge ending COMMIT.
  - READY is high again from cycle T+NUM_VOICES+2.
- Latency is NUM_VOICES+2 cycles; maximum throughput is one event per NUM_VOICES+2 cycles (per NUM_VOICES+3 when a pending service intervenes).
- TRIG and STEAL are high for exactly one cycle.
- IN_ALL_OFF or a sustain falling edge arriving during SCAN/COMMIT is latched and serviced in the first IDLE cycle after COMMIT, before the next event.
- VALID may be held high while READY=0; no event is lost or duplicated.

## Test plan
- NUM_VOICES=4, note-on 60/100:
  - Voice0 note=60, vel=100, gate=1.
  - TRIG=4'b0001 for one cycle, 6 cycles after the handshake.
  - OUT_ACTIVE_COUNT=1.
- Note-ons 60, 62, 64, 65, then 67:
  - 67 takes voice0 (age 3, oldest); OUT_STEAL pulses.
  - Count stays 4; voices 1..3 are unchanged.
- With 62 playing on voice1, note-on 62/50:
  - Voice1 vel=50 and TRIG[1] pulses.
  - No steal; count unchanged.
- Sustain:
  - IN_SUSTAIN=1, then note-off 60: voice0 gate stays 1.
  - Sustain falls: voice0 gate drops one IDLE cycle later; count decrements.
- Note-on 64 with vel=0 while 64 plays: voice gate drops.
- Note-off 70 (not playing): no output change; READY returns after 6 cycles.
- IN_ALL_OFF pulsed mid-SCAN: the event commits, then all gates are 0 one cycle later.
- Reset asserted mid-SCAN: all outputs are 0 and READY=1 the cycle after release.
